alu_share_ctrl: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests (opcode plus operands) from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It drives the ALU's `A`, `B` and `ALU_SEL` inputs from registered operands, captures `ALU_RES`, and returns the result with a requester ID over a backpressured response channel. The ALU stays a separate combinational instance; this block owns all sequencing around it.

---
 rtl/alu_share_ctrl.sv | 115 +++++++++++
 tb/tb_alu_share_ctrl.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer wrapping a shared combinational ALU.
// Two valid/ready requesters in, one backpressured response channel out.
module alu_share_ctrl #(
  parameter int W    = 8,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SELW-1:0] req0_sel,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SELW-1:0] req1_sel,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [SELW-1:0] alu_sel,
  input  logic [W-1:0]    alu_res,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_id,
  output logic            rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rr;
  logic            grant0;
  logic            grant1;
  logic            accept;
  logic            id_q;
  logic [SELW-1:0] sel_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Grant is offered only in IDLE; rr breaks ties when both requesters are valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = !rr;
        grant1 = rr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = (req0_valid & grant0) | (req1_valid & grant1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= 1'b0;
      id_q      <= 1'b0;
      sel_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      if (accept) begin
        sel_q <= grant1 ? req1_sel : req0_sel;
        a_q   <= grant1 ? req1_a   : req0_a;
        b_q   <= grant1 ? req1_b   : req0_b;
        id_q  <= grant1;
        rr    <= !grant1;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_res;
        rsp_zero  <= (alu_res == '0);
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Operand registers only load on accept, so the ALU inputs hold outside EXEC.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;
  assign rsp_id  = id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a stand-in ALU plus a transaction-level model
// of arbitration, latency and response ordering checked every cycle.
module tb_alu_share_ctrl;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    logic [7:0] data;
    logic       id;
    logic       zero;
    int         cyc;
  } rsp_t;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_sel, req1_sel, alu_sel;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0] alu_a, alu_b, alu_res;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [7:0] rsp_data;

  int checks   = 0;
  int failures = 0;

  // Stimulus state
  op_t  q0[$];
  op_t  q1[$];
  bit   hold0 = 0;
  bit   hold1 = 0;
  bit   rsp_rdy = 0;
  int   cyc = 0;

  // Transaction-level model
  bit   m_busy = 0;
  int   m_age  = 0;
  op_t  m_op   = '0;
  bit   m_id   = 0;
  bit   m_rr   = 0;
  op_t  m_last = '0;

  // Observations
  rsp_t got[$];
  int   obs_acc[$];

  alu_share_ctrl #(.W(8), .SELW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU: sixteen distinct 8-bit functions.
  function automatic logic [7:0] alu_fn(input logic [3:0] s, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return p[7:0];
      4'h3: return (b == 8'h00) ? 8'hFF : a / b;
      4'h4: return a | b;
      4'h5: return a & b;
      4'h6: return a ^ b;
      4'h7: return ~(a | b);
      4'h8: return ~(a & b);
      4'h9: return ~(a ^ b);
      4'hA: return {a[6:0], 1'b0};
      4'hB: return {1'b0, a[7:1]};
      4'hC: return {a[6:0], a[7]};
      4'hD: return {a[0], a[7:1]};
      4'hE: return {7'b0, (a > b)};
      default: return {7'b0, (a == b)};
    endcase
  endfunction

  assign alu_res = alu_fn(alu_sel, alu_a, alu_b);

  function automatic op_t rand_op();
    op_t o;
    o.sel = 4'($urandom);
    o.a   = 8'($urandom);
    o.b   = 8'($urandom);
    return o;
  endfunction

  // One clock cycle: drive, sample at negedge against the model, advance the model.
  task automatic tick();
    int         g;
    bit         fire;
    op_t        cur0, cur1;
    logic [7:0] exp_d;
    cur0 = (q0.size() > 0) ? q0[0] : rand_op();
    cur1 = (q1.size() > 0) ? q1[0] : rand_op();
    req0_valid = (q0.size() > 0) && !hold0;
    req1_valid = (q1.size() > 0) && !hold1;
    {req0_sel, req0_a, req0_b} = cur0;
    {req1_sel, req1_a, req1_b} = cur1;
    rsp_ready = rsp_rdy;
    @(negedge clk);
    g = -1;
    if (!rst && !m_busy) begin
      if (req0_valid && req1_valid) g = int'(m_rr);
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    checks++;
    if (req0_ready !== (g == 0)) begin
      failures++;
      $display("FAIL ready0 cyc=%0d got=%b exp=%b", cyc, req0_ready, (g == 0));
    end
    checks++;
    if (req1_ready !== (g == 1)) begin
      failures++;
      $display("FAIL ready1 cyc=%0d got=%b exp=%b", cyc, req1_ready, (g == 1));
    end
    checks++;
    if ({alu_sel, alu_a, alu_b} !== m_last) begin
      failures++;
      $display("FAIL alu_operands cyc=%0d got=%h exp=%h", cyc, {alu_sel, alu_a, alu_b}, m_last);
    end
    exp_d = alu_fn(m_op.sel, m_op.a, m_op.b);
    checks++;
    if (m_busy && m_age == 2) begin
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== m_id ||
          rsp_zero !== (exp_d == 8'h00)) begin
        failures++;
        $display("FAIL response cyc=%0d got v=%b d=%h id=%b z=%b exp v=1 d=%h id=%b z=%b",
                 cyc, rsp_valid, rsp_data, rsp_id, rsp_zero, exp_d, m_id, (exp_d == 8'h00));
      end
    end else if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_valid_idle cyc=%0d got=%b exp=0", cyc, rsp_valid);
    end
    fire = m_busy && m_age == 2 && rsp_ready;
    if (rsp_valid === 1'b1 && rsp_ready) got.push_back('{rsp_data, rsp_id, rsp_zero, cyc});
    if ((req0_valid && req0_ready === 1'b1) || (req1_valid && req1_ready === 1'b1))
      obs_acc.push_back(cyc);
    @(posedge clk);
    if (rst) begin
      m_busy = 0;
      m_rr   = 0;
      m_last = '0;
    end else if (g >= 0) begin
      m_op   = (g == 1) ? q1.pop_front() : q0.pop_front();
      m_id   = (g == 1);
      m_rr   = (g == 0);
      m_busy = 1;
      m_age  = 1;
      m_last = m_op;
    end else if (m_busy && m_age == 1) begin
      m_age = 2;
    end else if (fire) begin
      m_busy = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout got=%0d cycles exp=<%0d", name, n, budget);
    end
  endtask

  task automatic wait_age(input int age, input string name);
    int n = 0;
    while (!(m_busy && m_age == age) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL %s_wait got=timeout exp=age%0d", name, age);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_zero, alu_sel, alu_a, alu_b} !== 30'h0) begin
      failures++;
      $display("FAIL %s got v=%b d=%h id=%b z=%b sel=%h a=%h b=%h exp all zero", name,
               rsp_valid, rsp_data, rsp_id, rsp_zero, alu_sel, alu_a, alu_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q0.push_back('{4'h3, 8'h11, 8'h22});
    q1.push_back('{4'h5, 8'h33, 8'h44});
    tick();
    tick();
    check_reset_outputs("reset_values");
    q0.delete();
    q1.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_add();
    got.delete();
    obs_acc.delete();
    rsp_rdy = 1;
    q0.push_back('{4'h0, 8'h05, 8'h03});
    run_until_idle(20, "single_add");
    checks++;
    if (got.size() != 1 || obs_acc.size() != 1) begin
      failures++;
      $display("FAIL single_add_count got rsp=%0d acc=%0d exp 1/1", got.size(), obs_acc.size());
    end else begin
      checks++;
      if (got[0].data !== 8'h08 || got[0].id !== 1'b0 || got[0].zero !== 1'b0) begin
        failures++;
        $display("FAIL single_add got d=%h id=%b z=%b exp d=08 id=0 z=0",
                 got[0].data, got[0].id, got[0].zero);
      end
      checks++;
      if (got[0].cyc - obs_acc[0] != 2) begin
        failures++;
        $display("FAIL single_add_latency got=%0d exp=2", got[0].cyc - obs_acc[0]);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    got.delete();
    rsp_rdy = 1;
    q0.push_back('{4'h1, 8'h10, 8'h10});
    q1.push_back('{4'h4, 8'hF0, 8'h0F});
    run_until_idle(30, "contention");
    q0.push_back('{4'h0, 8'h01, 8'h01});
    q1.push_back('{4'h0, 8'h02, 8'h02});
    run_until_idle(30, "contention_again");
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL contention_count got=%0d exp=4", got.size());
    end else begin
      checks++;
      if (got[0].id !== 1'b0 || got[0].data !== 8'h00 || got[0].zero !== 1'b1) begin
        failures++;
        $display("FAIL contention_first got id=%b d=%h z=%b exp id=0 d=00 z=1",
                 got[0].id, got[0].data, got[0].zero);
      end
      checks++;
      if (got[1].id !== 1'b1 || got[1].data !== 8'hFF || got[1].zero !== 1'b0) begin
        failures++;
        $display("FAIL contention_second got id=%b d=%h z=%b exp id=1 d=FF z=0",
                 got[1].id, got[1].data, got[1].zero);
      end
      checks++;
      if (got[2].id !== 1'b0 || got[2].data !== 8'h02) begin
        failures++;
        $display("FAIL contention_rr_back got id=%b d=%h exp id=0 d=02", got[2].id, got[2].data);
      end
    end
  endtask

  task automatic test_backpressure();
    op_t o;
    got.delete();
    rsp_rdy = 1;
    o = rand_op();
    q0.push_back(o);
    wait_age(2, "backpressure");
    rsp_rdy = 0;
    q1.push_back(rand_op());
    repeat (5) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== alu_fn(o.sel, o.a, o.b)) begin
        failures++;
        $display("FAIL backpressure_hold got v=%b d=%h exp v=1 d=%h",
                 rsp_valid, rsp_data, alu_fn(o.sel, o.a, o.b));
      end
    end
    checks++;
    if (got.size() != 0) begin
      failures++;
      $display("FAIL backpressure_stall got=%0d rsp exp=0", got.size());
    end
    rsp_rdy = 1;
    tick();
    checks++;
    if (got.size() != 1) begin
      failures++;
      $display("FAIL backpressure_release got=%0d rsp exp=1", got.size());
    end
    run_until_idle(20, "backpressure_drain");
    checks++;
    if (got.size() != 2) begin
      failures++;
      $display("FAIL backpressure_total got=%0d rsp exp=2", got.size());
    end
  endtask

  task automatic test_fairness();
    do_reset();
    got.delete();
    obs_acc.delete();
    rsp_rdy = 1;
    repeat (4) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run_until_idle(60, "fairness");
    checks++;
    if (got.size() != 8 || obs_acc.size() != 8) begin
      failures++;
      $display("FAIL fairness_count got rsp=%0d acc=%0d exp 8/8", got.size(), obs_acc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i].id !== 1'(i % 2)) begin
          failures++;
          $display("FAIL fairness_id[%0d] got=%b exp=%0d", i, got[i].id, i % 2);
        end
      end
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (obs_acc[i] - obs_acc[i-1] != 3) begin
          failures++;
          $display("FAIL fairness_spacing[%0d] got=%0d exp=3", i, obs_acc[i] - obs_acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_opcode_sweep();
    got.delete();
    rsp_rdy = 1;
    for (int i = 0; i < 16; i++) q1.push_back('{4'(i), 8'hA5, 8'h3C});
    run_until_idle(80, "opcode_sweep");
    checks++;
    if (got.size() != 16) begin
      failures++;
      $display("FAIL opcode_sweep_count got=%0d exp=16", got.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got[i].data !== alu_fn(4'(i), 8'hA5, 8'h3C) || got[i].id !== 1'b1) begin
          failures++;
          $display("FAIL opcode_sweep[%0d] got d=%h id=%b exp d=%h id=1", i, got[i].data,
                   got[i].id, alu_fn(4'(i), 8'hA5, 8'h3C));
        end
      end
      checks++;
      if (got[13].data !== 8'hD2) begin
        failures++;
        $display("FAIL opcode_sweep_rotr got=%h exp=D2", got[13].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    rsp_rdy = 1;
    q0.push_back(rand_op());
    wait_age(1, "reset_exec");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset_in_exec");
    rsp_rdy = 0;
    q1.push_back(rand_op());
    wait_age(2, "reset_resp");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset_in_resp");
    tick();
    checks++;
    if (got.size() != 0) begin
      failures++;
      $display("FAIL reset_no_response got=%0d rsp exp=0", got.size());
    end
    rsp_rdy = 1;
    q0.push_back(rand_op());
    q1.push_back(rand_op());
    run_until_idle(30, "reset_recover");
    checks++;
    if (got.size() != 2 || got[0].id !== 1'b0) begin
      failures++;
      $display("FAIL reset_recover got n=%0d first_id=%b exp n=2 first_id=0", got.size(),
               (got.size() > 0) ? got[0].id : 1'bx);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    got.delete();
    for (int c = 0; c < 600; c++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) begin
        q0.push_back(rand_op());
        pushed++;
      end
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) begin
        q1.push_back(rand_op());
        pushed++;
      end
      hold0   = ($urandom_range(0, 3) == 0);
      hold1   = ($urandom_range(0, 3) == 0);
      rsp_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    hold0   = 0;
    hold1   = 0;
    rsp_rdy = 1;
    run_until_idle(200, "random_drain");
    checks++;
    if (got.size() != pushed) begin
      failures++;
      $display("FAIL random_count got=%0d exp=%0d", got.size(), pushed);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_fairness();
    test_opcode_sweep();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=expired exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
